// File: rtl/fifo_chk_pkg.sv
// Shared types for the FIFO self-checker.
// Flag enum order fixes the bit layout of every flag vector.
package fifo_chk_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT
  } chk_state_e;

  typedef enum logic [2:0] {
    DATA   = 3'd0,
    FULL   = 3'd1,
    EMPTY  = 3'd2,
    AFULL  = 3'd3,
    AEMPTY = 3'd4,
    OVF    = 3'd5,
    UDF    = 3'd6,
    ACK    = 3'd7
  } flag_idx_e;

  localparam int NUM_FLAGS = 8;

  function automatic logic [NUM_FLAGS-1:0] flag_bit(
    input flag_idx_e f,
    input logic      hit
  );
    logic [NUM_FLAGS-1:0] v;
    v    = '0;
    v[f] = hit;
    return v;
  endfunction

endpackage

// File: rtl/fifo_ref_model.sv
// Cycle-accurate shadow FIFO that predicts every observed status.
// Pointers wrap at DEPTH-1, so any depth >= 2 is supported.
module fifo_ref_model #(
  parameter  int FIFO_WIDTH = 16,
  parameter  int FIFO_DEPTH = 8,
  localparam int PW = $clog2(FIFO_DEPTH),
  localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [FIFO_WIDTH-1:0] data_in,
  output logic                  wr_ack_m,
  output logic                  overflow_m,
  output logic                  underflow_m,
  output logic [FIFO_WIDTH-1:0] data_out_m,
  output logic                  full_m,
  output logic                  empty_m,
  output logic                  almostfull_m,
  output logic                  almostempty_m,
  output logic                  rd_valid_m,
  output logic [CW-1:0]         count_m
);

  logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  wr_ack_q, wr_ack_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic                  rdv_q, rdv_d;
  logic [FIFO_WIDTH-1:0] dout_q, dout_d;
  logic                  wr_acc, rd_acc;

  always_comb begin
    full_m        = count_q == CW'(FIFO_DEPTH);
    empty_m       = count_q == '0;
    almostfull_m  = count_q == CW'(FIFO_DEPTH - 1);
    almostempty_m = count_q == CW'(1);
    // full blocks the write and empty blocks the read on a collision
    wr_acc   = wr_en && !full_m;
    rd_acc   = rd_en && !empty_m;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_acc) begin
      wr_ptr_d = (wr_ptr_q == PW'(FIFO_DEPTH - 1))
               ? '0 : wr_ptr_q + PW'(1);
    end
    if (rd_acc) begin
      rd_ptr_d = (rd_ptr_q == PW'(FIFO_DEPTH - 1))
               ? '0 : rd_ptr_q + PW'(1);
    end
    count_d  = count_q + CW'(wr_acc) - CW'(rd_acc);
    wr_ack_d = wr_acc;
    ovf_d    = wr_en && full_m;
    udf_d    = rd_en && empty_m;
    rdv_d    = rd_acc;
    dout_d   = rd_acc ? mem_q[rd_ptr_q] : dout_q;
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      wr_ack_q <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      rdv_q    <= 1'b0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      wr_ack_q <= wr_ack_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      rdv_q    <= rdv_d;
      dout_q   <= dout_d;
    end
  end

  assign wr_ack_m    = wr_ack_q;
  assign overflow_m  = ovf_q;
  assign underflow_m = udf_q;
  assign data_out_m  = dout_q;
  assign rd_valid_m  = rdv_q;
  assign count_m     = count_q;

endmodule

// File: rtl/fifo_checker.sv
// Passive FIFO self-checker: compares observed FIFO status to a model,
// keeps sticky flags, saturating counters and a first-failure capture.
module fifo_checker
  import fifo_chk_pkg::*;
#(
  parameter  int FIFO_WIDTH  = 16,
  parameter  int FIFO_DEPTH  = 8,
  parameter  int CNT_W       = 16,
  parameter  int STOP_ON_ERR = 0,
  localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sample_en,
  input  logic                  clear,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic [FIFO_WIDTH-1:0] data_out,
  input  logic                  wr_ack,
  input  logic                  overflow,
  input  logic                  underflow,
  input  logic                  full,
  input  logic                  empty,
  input  logic                  almostfull,
  input  logic                  almostempty,
  output logic [NUM_FLAGS-1:0]  err_flags,
  output logic [CNT_W-1:0]      pass_cnt,
  output logic [CNT_W-1:0]      err_cnt,
  output logic [CNT_W-1:0]      cycle_cnt,
  output logic                  first_err_valid,
  output logic [CNT_W-1:0]      first_err_cycle,
  output logic [NUM_FLAGS-1:0]  first_err_flags,
  output logic [CW-1:0]         exp_count,
  output logic                  halted
);

  logic                  wr_ack_m, overflow_m, underflow_m;
  logic [FIFO_WIDTH-1:0] data_out_m;
  logic                  full_m, empty_m;
  logic                  almostfull_m, almostempty_m;
  logic                  rd_valid_m;

  fifo_ref_model #(
    .FIFO_WIDTH (FIFO_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_model (
    .clk           (clk),
    .rst           (rst),
    .wr_en         (wr_en),
    .rd_en         (rd_en),
    .data_in       (data_in),
    .wr_ack_m      (wr_ack_m),
    .overflow_m    (overflow_m),
    .underflow_m   (underflow_m),
    .data_out_m    (data_out_m),
    .full_m        (full_m),
    .empty_m       (empty_m),
    .almostfull_m  (almostfull_m),
    .almostempty_m (almostempty_m),
    .rd_valid_m    (rd_valid_m),
    .count_m       (exp_count)
  );

  chk_state_e           state_q, state_d;
  logic [CNT_W-1:0]     pass_q, pass_d;
  logic [CNT_W-1:0]     err_q, err_d;
  logic [CNT_W-1:0]     cyc_q, cyc_d;
  logic [NUM_FLAGS-1:0] flags_q, flags_d;
  logic                 fev_q, fev_d;
  logic [CNT_W-1:0]     fecyc_q, fecyc_d;
  logic [NUM_FLAGS-1:0] fefl_q, fefl_d;
  logic [NUM_FLAGS-1:0] mm;
  logic                 active, hit;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    mm = flag_bit(DATA, rd_valid_m && (data_out != data_out_m))
       | flag_bit(FULL, full != full_m)
       | flag_bit(EMPTY, empty != empty_m)
       | flag_bit(AFULL, almostfull != almostfull_m)
       | flag_bit(AEMPTY, almostempty != almostempty_m)
       | flag_bit(OVF, overflow != overflow_m)
       | flag_bit(UDF, underflow != underflow_m)
       | flag_bit(ACK, wr_ack != wr_ack_m);
    active  = (state_q == RUN) && sample_en;
    hit     = active && (mm != '0);
    state_d = state_q;
    pass_d  = pass_q;
    err_d   = err_q;
    cyc_d   = cyc_q;
    flags_d = flags_q;
    fev_d   = fev_q;
    fecyc_d = fecyc_q;
    fefl_d  = fefl_q;
    unique case (state_q)
      IDLE: if (sample_en) state_d = RUN;
      RUN: begin
        if (!sample_en) begin
          state_d = IDLE;
        end else if ((STOP_ON_ERR != 0) && hit && !clear) begin
          state_d = HALT;
        end
      end
      HALT: if (clear) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clear) begin
      pass_d  = '0;
      err_d   = '0;
      cyc_d   = '0;
      flags_d = '0;
      fev_d   = 1'b0;
      fecyc_d = '0;
      fefl_d  = '0;
    end else if (active) begin
      cyc_d = sat_inc(cyc_q);
      if (hit) begin
        err_d   = sat_inc(err_q);
        flags_d = flags_q | mm;
        if (!fev_q) begin
          fev_d   = 1'b1;
          fecyc_d = cyc_q;
          fefl_d  = mm;
        end
      end else begin
        pass_d = sat_inc(pass_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pass_q  <= '0;
      err_q   <= '0;
      cyc_q   <= '0;
      flags_q <= '0;
      fev_q   <= 1'b0;
      fecyc_q <= '0;
      fefl_q  <= '0;
    end else begin
      state_q <= state_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      cyc_q   <= cyc_d;
      flags_q <= flags_d;
      fev_q   <= fev_d;
      fecyc_q <= fecyc_d;
      fefl_q  <= fefl_d;
    end
  end

  assign err_flags       = flags_q;
  assign pass_cnt        = pass_q;
  assign err_cnt         = err_q;
  assign cycle_cnt       = cyc_q;
  assign first_err_valid = fev_q;
  assign first_err_cycle = fecyc_q;
  assign first_err_flags = fefl_q;
  assign halted          = state_q == HALT;

endmodule

// File: tb/tb_fifo_checker.sv
// Scoreboard bench: two checkers (depth 8 free-running, depth 5 halting)
// watch bench FIFOs whose status lines can be corrupted per signal.
module tb_fifo_checker;
  import fifo_chk_pkg::*;

  localparam int FD_ERR   = 0;
  localparam int FD_PASS  = 1;
  localparam int FD_CYC   = 2;
  localparam int FD_FLAGS = 3;
  localparam int FD_HALT  = 4;
  localparam int FD_EXPC  = 5;
  localparam int FD_FEV   = 6;
  localparam int FD_FECYC = 7;
  localparam int FD_FEFL  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [15:0] data_in = '0;
  logic        sample_en [2];
  logic        clear [2];
  logic [7:0]  flip [2];

  logic        f_ack [2];
  logic        f_ovf [2];
  logic        f_udf [2];
  logic [15:0] f_dout [2];
  int          fcnt [2];
  logic [15:0] fq [2][$];
  bit          f_wa, f_ra;
  logic [15:0] f_tmp;

  logic        o_ack [2], o_ovf [2], o_udf [2];
  logic        o_full [2], o_empty [2], o_af [2], o_ae [2];
  logic [15:0] o_dout [2];

  logic [7:0]  eflags [2], feflags [2];
  logic [15:0] pcnt [2], ecnt [2], ccnt [2], fecyc [2];
  logic        fev [2], hlt [2];
  logic [3:0]  expc_a;
  logic [2:0]  expc_b;

  typedef struct {
    int    due;
    int    inst;
    int    fld;
    int    val;
    string name;
  } exp_t;

  exp_t sb [$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   fin = 1'b0;
  bit   fin_seen = 1'b0;

  function automatic int dep(input int k);
    return (k == 0) ? 8 : 5;
  endfunction

  // Bench-side FIFOs: a queue with registered ack/ovf/udf/data
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        fq[k].delete();
        fcnt[k]   <= 0;
        f_ack[k]  <= 1'b0;
        f_ovf[k]  <= 1'b0;
        f_udf[k]  <= 1'b0;
        f_dout[k] <= '0;
      end else begin
        f_wa = wr_en && (fq[k].size() < dep(k));
        f_ra = rd_en && (fq[k].size() > 0);
        f_ack[k] <= f_wa;
        f_ovf[k] <= wr_en && (fq[k].size() == dep(k));
        f_udf[k] <= rd_en && (fq[k].size() == 0);
        if (f_ra) begin
          f_tmp = fq[k].pop_front();
          f_dout[k] <= f_tmp;
        end
        if (f_wa) fq[k].push_back(data_in);
        fcnt[k] <= fq[k].size();
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      o_full[k]  = (fcnt[k] == dep(k)) ^ flip[k][FULL];
      o_empty[k] = (fcnt[k] == 0) ^ flip[k][EMPTY];
      o_af[k]    = (fcnt[k] == dep(k) - 1) ^ flip[k][AFULL];
      o_ae[k]    = (fcnt[k] == 1) ^ flip[k][AEMPTY];
      o_ack[k]   = f_ack[k] ^ flip[k][ACK];
      o_ovf[k]   = f_ovf[k] ^ flip[k][OVF];
      o_udf[k]   = f_udf[k] ^ flip[k][UDF];
      o_dout[k]  = f_dout[k] ^ {16{flip[k][DATA]}};
    end
  end

  fifo_checker #(
    .FIFO_WIDTH (16), .FIFO_DEPTH (8),
    .CNT_W (16), .STOP_ON_ERR (0)
  ) u_dut_a (
    .clk (clk), .rst (rst),
    .sample_en (sample_en[0]), .clear (clear[0]),
    .wr_en (wr_en), .rd_en (rd_en),
    .data_in (data_in), .data_out (o_dout[0]),
    .wr_ack (o_ack[0]), .overflow (o_ovf[0]),
    .underflow (o_udf[0]), .full (o_full[0]),
    .empty (o_empty[0]), .almostfull (o_af[0]),
    .almostempty (o_ae[0]),
    .err_flags (eflags[0]), .pass_cnt (pcnt[0]),
    .err_cnt (ecnt[0]), .cycle_cnt (ccnt[0]),
    .first_err_valid (fev[0]),
    .first_err_cycle (fecyc[0]),
    .first_err_flags (feflags[0]),
    .exp_count (expc_a), .halted (hlt[0])
  );

  fifo_checker #(
    .FIFO_WIDTH (16), .FIFO_DEPTH (5),
    .CNT_W (16), .STOP_ON_ERR (1)
  ) u_dut_b (
    .clk (clk), .rst (rst),
    .sample_en (sample_en[1]), .clear (clear[1]),
    .wr_en (wr_en), .rd_en (rd_en),
    .data_in (data_in), .data_out (o_dout[1]),
    .wr_ack (o_ack[1]), .overflow (o_ovf[1]),
    .underflow (o_udf[1]), .full (o_full[1]),
    .empty (o_empty[1]), .almostfull (o_af[1]),
    .almostempty (o_ae[1]),
    .err_flags (eflags[1]), .pass_cnt (pcnt[1]),
    .err_cnt (ecnt[1]), .cycle_cnt (ccnt[1]),
    .first_err_valid (fev[1]),
    .first_err_cycle (fecyc[1]),
    .first_err_flags (feflags[1]),
    .exp_count (expc_b), .halted (hlt[1])
  );

  function automatic int get(input int inst, input int fld);
    case (fld)
      FD_ERR:   return int'(ecnt[inst]);
      FD_PASS:  return int'(pcnt[inst]);
      FD_CYC:   return int'(ccnt[inst]);
      FD_FLAGS: return int'(eflags[inst]);
      FD_HALT:  return int'(hlt[inst]);
      FD_EXPC:  return (inst == 0) ? int'(expc_a) : int'(expc_b);
      FD_FEV:   return int'(fev[inst]);
      FD_FECYC: return int'(fecyc[inst]);
      FD_FEFL:  return int'(feflags[inst]);
      default:  return -1;
    endcase
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every expectation is due at the negedge after its edge
  always @(negedge clk) begin
    exp_t e;
    int   act;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e   = sb.pop_front();
      act = get(e.inst, e.fld);
      checks++;
      if (e.due != cyc) begin
        errors++;
        $display("FAIL %s: missed, due cycle %0d seen at %0d",
                 e.name, e.due, cyc);
      end else if (act != e.val) begin
        errors++;
        $display("FAIL %s: got 0x%0h expected 0x%0h",
                 e.name, act, e.val);
      end
    end
    if (fin && !fin_seen) begin
      fin_seen = 1'b1;
      checks++;
      if (sb.size() != 0) begin
        errors++;
        $display("FAIL scoreboard_drain: got %0d left expected 0",
                 sb.size());
      end
    end
  end

  task automatic expect_v(input int inst, input int fld,
                          input int val, input string name);
    exp_t e;
    e.due  = cyc + 1;
    e.inst = inst;
    e.fld  = fld;
    e.val  = val;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic expect_zero(input int inst, input string tag);
    expect_v(inst, FD_ERR, 0, {tag, "_err"});
    expect_v(inst, FD_PASS, 0, {tag, "_pass"});
    expect_v(inst, FD_CYC, 0, {tag, "_cyc"});
    expect_v(inst, FD_FLAGS, 0, {tag, "_flags"});
    expect_v(inst, FD_HALT, 0, {tag, "_halt"});
    expect_v(inst, FD_FEV, 0, {tag, "_fev"});
    expect_v(inst, FD_FECYC, 0, {tag, "_fecyc"});
    expect_v(inst, FD_FEFL, 0, {tag, "_fefl"});
    expect_v(inst, FD_EXPC, 0, {tag, "_expc"});
  endtask

  task automatic step(input bit w, input bit r, input logic [15:0] d);
    wr_en   = w;
    rd_en   = r;
    data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input bit sa, input bit sbv);
    sample_en[0] = sa;
    sample_en[1] = sbv;
    rst = 1'b1;
    step(0, 0, '0);
    step(0, 0, '0);
    rst = 1'b0;
    step(0, 0, '0);
  endtask

  initial begin
    sample_en[0] = 1'b0;
    sample_en[1] = 1'b0;
    clear[0]     = 1'b0;
    clear[1]     = 1'b0;
    flip[0]      = '0;
    flip[1]      = '0;

    // reset state
    step(0, 0, '0);
    expect_zero(0, "rst_a");
    expect_zero(1, "rst_b");
    step(0, 0, '0);
    rst = 1'b0;

    // fill and drain, depth 8
    do_reset(1, 0);
    for (int i = 1; i <= 8; i++) begin
      if (i == 8) expect_v(0, FD_EXPC, 8, "fill_expc");
      step(1, 0, 16'(i));
    end
    for (int i = 0; i < 8; i++) step(0, 1, '0);
    expect_v(0, FD_ERR, 0, "drain_err");
    expect_v(0, FD_PASS, 17, "drain_pass");
    expect_v(0, FD_CYC, 17, "drain_cyc");
    expect_v(0, FD_FLAGS, 0, "drain_flags");
    expect_v(0, FD_EXPC, 0, "drain_expc");
    step(0, 0, '0);

    // overflow and underflow reported correctly, then a missed overflow
    do_reset(1, 0);
    for (int i = 0; i < 9; i++) step(1, 0, 16'(16'h10 + i));
    for (int i = 0; i < 9; i++) step(0, 1, '0);
    expect_v(0, FD_ERR, 0, "ovud_err");
    expect_v(0, FD_PASS, 19, "ovud_pass");
    step(0, 0, '0);
    for (int i = 0; i < 9; i++) step(1, 0, 16'(16'h30 + i));
    flip[0][OVF] = 1'b1;
    expect_v(0, FD_FLAGS, 32'h20, "ovf_flags");
    expect_v(0, FD_ERR, 1, "ovf_err");
    expect_v(0, FD_PASS, 28, "ovf_pass");
    expect_v(0, FD_CYC, 29, "ovf_cyc");
    expect_v(0, FD_FEV, 1, "ovf_fev");
    expect_v(0, FD_FECYC, 28, "ovf_fecyc");
    expect_v(0, FD_FEFL, 32'h20, "ovf_fefl");
    step(0, 0, '0);
    flip[0] = '0;

    // simultaneous write and read at empty
    do_reset(1, 0);
    expect_v(0, FD_EXPC, 1, "simul_expc");
    step(1, 1, 16'hAAAA);
    flip[0][EMPTY]  = 1'b1;
    flip[0][AEMPTY] = 1'b1;
    expect_v(0, FD_FLAGS, 32'h14, "simul_flags");
    expect_v(0, FD_ERR, 1, "simul_err");
    expect_v(0, FD_PASS, 1, "simul_pass");
    expect_v(0, FD_FECYC, 1, "simul_fecyc");
    expect_v(0, FD_FEFL, 32'h14, "simul_fefl");
    step(0, 0, '0);
    flip[0] = '0;

    // depth 5 wrap with interleaved traffic
    do_reset(0, 1);
    for (int i = 0; i < 4; i++) begin
      expect_v(1, FD_EXPC, i + 1, "wrap_fill_expc");
      step(1, 0, 16'(16'h40 + i));
    end
    for (int i = 0; i < 12; i++) begin
      expect_v(1, FD_EXPC, 4, "wrap_pair_expc");
      step(1, 1, 16'(16'h100 + i));
    end
    expect_v(1, FD_EXPC, 5, "wrap_full_expc");
    step(1, 0, 16'h01FF);
    expect_v(1, FD_EXPC, 4, "wrap_fullrw_expc");
    step(1, 1, 16'h02FF);
    expect_v(1, FD_ERR, 0, "wrap_err");
    expect_v(1, FD_PASS, 19, "wrap_pass");
    expect_v(1, FD_HALT, 0, "wrap_halt");
    step(0, 0, '0);

    // halt on a corrupted third read
    do_reset(0, 1);
    for (int i = 0; i < 4; i++) step(1, 0, 16'(16'h21 + i));
    for (int i = 0; i < 3; i++) step(0, 1, '0);
    flip[1][DATA] = 1'b1;
    expect_v(1, FD_HALT, 1, "halt_halt");
    expect_v(1, FD_ERR, 1, "halt_err");
    expect_v(1, FD_FLAGS, 1, "halt_flags");
    expect_v(1, FD_FEFL, 1, "halt_fefl");
    expect_v(1, FD_FECYC, 7, "halt_fecyc");
    expect_v(1, FD_PASS, 7, "halt_pass");
    expect_v(1, FD_CYC, 8, "halt_cyc");
    step(0, 0, '0);
    flip[1] = '0;
    flip[1][FULL] = 1'b1;
    step(0, 0, '0);
    flip[1] = '0;
    expect_v(1, FD_ERR, 1, "frozen_err");
    expect_v(1, FD_PASS, 7, "frozen_pass");
    expect_v(1, FD_CYC, 8, "frozen_cyc");
    expect_v(1, FD_HALT, 1, "frozen_halt");
    step(0, 0, '0);
    clear[1] = 1'b1;
    expect_v(1, FD_ERR, 0, "clr_err");
    expect_v(1, FD_PASS, 0, "clr_pass");
    expect_v(1, FD_CYC, 0, "clr_cyc");
    expect_v(1, FD_FLAGS, 0, "clr_flags");
    expect_v(1, FD_HALT, 0, "clr_halt");
    expect_v(1, FD_FEV, 0, "clr_fev");
    expect_v(1, FD_EXPC, 1, "clr_expc");
    step(0, 0, '0);
    clear[1] = 1'b0;
    expect_v(1, FD_CYC, 0, "resume_idle_cyc");
    step(0, 0, '0);
    expect_v(1, FD_PASS, 1, "resume_pass");
    expect_v(1, FD_ERR, 0, "resume_err");
    step(0, 0, '0);

    // reset mid-fill with an error already recorded
    do_reset(1, 0);
    step(1, 0, 16'h0001);
    flip[0][FULL] = 1'b1;
    step(1, 0, 16'h0002);
    flip[0] = '0;
    step(1, 0, 16'h0003);
    expect_v(0, FD_EXPC, 4, "mid_expc");
    expect_v(0, FD_ERR, 1, "mid_err");
    step(1, 0, 16'h0004);
    rst = 1'b1;
    expect_zero(0, "midrst");
    step(0, 0, '0);
    rst = 1'b0;
    step(0, 0, '0);

    fin = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_checker.md
# fifo_checker

Synthesizable, parametrised FIFO self-checker. It passively observes a FIFO's write/read handshakes and status outputs, runs a cycle-accurate internal reference model, and compares every monitored output against that model. It keeps sticky per-signal error flags, saturating pass/error counters and a first-failure capture. It sits beside any FIFO instance in the FIFO, SPI-slave or RAM environments, on-chip or in simulation, and replaces bench-side scoreboarding.

## Interface
- `FIFO_WIDTH`, 16, data width
- `FIFO_DEPTH`, 8, entries (≥2, any integer, not only powers of two)
- `CNT_W`, 16, width of pass/error/cycle counters
- `STOP_ON_ERR`, 0, 1 = freeze all checking after the first mismatch
- `clk`  in  1  clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `sample_en`  in  1  enables checking; the FSM stays in IDLE while low
- `clear`  in  1  clears counters, flags and capture; does not touch the model
- `wr_en`, `rd_en`  in  1  observed FIFO requests
- `data_in`  in  FIFO_WIDTH  observed write data
- `data_out`  in  FIFO_WIDTH  observed read data
- `wr_ack`, `overflow`, `underflow`, `full`, `empty`, `almostfull`, `almostempty`  in  1  observed FIFO status
- `err_flags`  out  8  sticky mismatch bit per signal, order set by the package enum
- `pass_cnt`, `err_cnt`, `cycle_cnt`  out  CNT_W  saturating counters
- `first_err_valid`  out  1
- `first_err_cycle`  out  CNT_W  `cycle_cnt` value at the first mismatch
- `first_err_flags`  out  8  mismatch vector of that cycle
- `exp_count`  out  $clog2(FIFO_DEPTH+1)  model occupancy
- `halted`  out  1  FSM is in HALT

## Operation
- Model semantics, with count = occupancy:
  - write accepted when `wr_en && !full_m`
  - read accepted when `rd_en && !empty_m`
  - when both are requested: empty accepts the write only; full accepts the read only; otherwise both are accepted and count is unchanged
- Model registered outputs, updated at the edge:
  - `wr_ack_m` = write accepted
  - `overflow_m` = `wr_en && full_m`
  - `underflow_m` = `rd_en && empty_m`
  - `data_out_m` = head word on an accepted read, else held
- Model combinational outputs:
  - `full_m` = count==DEPTH
  - `empty_m` = count==0
  - `almostfull_m` = count==DEPTH-1
  - `almostempty_m` = count==1
- Comparison:
  - At each rising edge in RUN, compare all DUT outputs with the model outputs present before the edge.
  - `data_out` is compared only in the cycle after an accepted read (`rd_valid_m`).
  - Pointers wrap at FIFO_DEPTH-1 → 0.
- FSM:
  - IDLE → RUN when `sample_en`.
  - RUN → IDLE when `!sample_en`.
  - RUN → HALT on any mismatch when STOP_ON_ERR=1.
  - HALT exits only on `rst` or `clear`; `clear` returns to IDLE.
- The model updates in every state, so it tracks the DUT even when not checking.
- Per checked cycle:
  - no mismatch → `pass_cnt`+1
  - any mismatch → `err_cnt`+1, OR the mismatch vector into `err_flags`
  - capture on the first mismatch only
- `cycle_cnt` increments every RUN cycle. All counters saturate at all-ones.

## Timing
- Reset values:
  - all outputs 0, except `halted`=0 and `exp_count`=0
  - model empty, pointers 0, `data_out_m` 0, FSM IDLE
- `rst` has priority over `clear`, and `clear` has priority over counting in the same cycle.
- Reset mid-operation empties the model. The DUT must share the reset, otherwise the next check mismatches.
- Result latency: a mismatch on sampled cycle N is visible on `err_cnt`, `err_flags` and the capture outputs after edge N, i.e. one cycle.
- `halted` asserts in the same cycle the first error becomes visible.

## Structure
- Package `fifo_chk_pkg`:
  - `chk_state_e` {IDLE, RUN, HALT}
  - flag index enum: DATA, FULL, EMPTY, AFULL, AEMPTY, OVF, UDF, ACK
  - `NUM_FLAGS`=8
- Sub-module `fifo_ref_model`:
  - shadow memory, pointers and count
  - parametrised by FIFO_WIDTH and FIFO_DEPTH
  - outputs all `*_m` signals and `rd_valid_m`
- Top level contains the FSM, compare logic, counters and capture.

## Test plan
- **Fill and drain:** DEPTH=8. 8 writes of 0x0001–0x0008 then 8 reads, with a correct DUT → `err_cnt`=0, `pass_cnt`=`cycle_cnt`, `data_out` sequence 1..8.
- **Overflow and underflow:** a 9th write on full, then a read on empty, with the DUT flagging both → 0 errors. Force DUT `overflow`=0 → `err_flags[OVF]`=1, `err_cnt`=1.
- **Simultaneous requests at empty:** `wr_en`=`rd_en`=1 with count 0 → model count 1, `underflow_m`=1. A DUT reporting count 0 flags EMPTY and AEMPTY.
- **Non-power-of-two wrap:** DEPTH=5, 12 interleaved write/read pairs → pointer wrap, 0 errors, `exp_count` never exceeds 5.
- **STOP_ON_ERR:** STOP_ON_ERR=1, corrupt `data_out` on the 3rd read → `halted`=1, `first_err_flags`=DATA only, counters frozen until `clear`.
- **Reset mid-fill:** `rst` asserted at count 4 → all outputs 0 and `exp_count`=0 the next cycle.
